// File: rtl/frida_scan_seq.sv
// frida_scan_seq: parametrised scan sequencer for the FRIDA comparator mux.
// Walks mux_sel over a latched channel mask. On each channel it waits out a
// settle window, counts comparator '1' decisions over a dwell of conversions,
// and hands one {channel, count} result to the readout over valid/ready.
// Build option: define FRIDA_SCAN_SYNC_EN to put 2-flop synchronisers on
// conv_done/comp_in and edge-detect conv_done (adds 2 cycles of latency).
module frida_scan_seq #(
  parameter int N_ADC      = 16,
  parameter int SEL_W      = 4,
  parameter int DWELL_W    = 8,
  parameter int SETTLE_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [N_ADC-1:0]   chan_mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               conv_done,
  input  logic               comp_in,
  output logic [SEL_W-1:0]   mux_sel,
  output logic               busy,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [SEL_W-1:0]   res_chan,
  output logic [DWELL_W-1:0] res_count,
  output logic               overrun
);

  localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, EMIT} state_t;

  typedef struct packed {
    logic [SEL_W-1:0]   chan;
    logic [DWELL_W-1:0] count;
  } res_t;

  state_t             state;
  res_t               res_q;
  logic [N_ADC-1:0]   mask_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               cont_q;
  logic [SC_W-1:0]    settle_cnt;
  logic [DWELL_W-1:0] conv_cnt;
  logic [DWELL_W-1:0] ones_cnt;
  logic [SEL_W:0]     nxt;      // {found, channel} of next set bit above mux_sel
  logic               conv_s;
  logic               comp_s;

  // Lowest set bit of a mask (callers guarantee the mask is non-zero).
  function automatic logic [SEL_W-1:0] lowest_bit(input logic [N_ADC-1:0] m);
    lowest_bit = '0;
    for (int i = N_ADC-1; i >= 0; i--)
      if (m[i]) lowest_bit = SEL_W'(i);
  endfunction

  // Next set bit strictly above cur; MSB of the result flags "found".
  function automatic logic [SEL_W:0] next_bit(input logic [N_ADC-1:0] m,
                                              input logic [SEL_W-1:0] cur);
    next_bit = '0;
    for (int i = N_ADC-1; i >= 0; i--)
      if (m[i] && (i > int'(cur))) next_bit = {1'b1, SEL_W'(i)};
  endfunction

`ifdef FRIDA_SCAN_SYNC_EN
  logic [1:0] conv_sync;
  logic [1:0] comp_sync;
  logic       conv_prev;

  // Two-flop synchronisers plus a delay tap for conv_done edge detection.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      conv_sync <= '0;
      comp_sync <= '0;
      conv_prev <= 1'b0;
    end else begin
      conv_sync <= {conv_sync[0], conv_done};
      comp_sync <= {comp_sync[0], comp_in};
      conv_prev <= conv_sync[1];
    end
  end

  assign conv_s = conv_sync[1] & ~conv_prev;
  assign comp_s = comp_sync[1];
`else
  assign conv_s = conv_done;
  assign comp_s = comp_in;
`endif

  // Candidate next channel for the EMIT -> SETTLE step.
  always_comb begin
    nxt = next_bit(mask_q, mux_sel);
  end

  assign busy      = (state != IDLE);
  assign res_chan  = res_q.chan;
  assign res_count = res_q.count;

  // Sequencer FSM; stop overrides everything except reset.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= IDLE;
      mux_sel    <= '0;
      res_valid  <= 1'b0;
      res_q      <= '0;
      overrun    <= 1'b0;
      mask_q     <= '0;
      dwell_q    <= '0;
      cont_q     <= 1'b0;
      settle_cnt <= '0;
      conv_cnt   <= '0;
      ones_cnt   <= '0;
    end else if (stop) begin
      state      <= IDLE;
      res_valid  <= 1'b0;
      settle_cnt <= '0;
      conv_cnt   <= '0;
      ones_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (|chan_mask) && (|dwell)) begin
            mask_q     <= chan_mask;
            dwell_q    <= dwell;
            cont_q     <= cont;
            overrun    <= 1'b0;
            mux_sel    <= lowest_bit(chan_mask);
            settle_cnt <= '0;
            conv_cnt   <= '0;
            ones_cnt   <= '0;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          // Conversions here belong to the previous mux setting: drop them.
          if (settle_cnt == SC_W'(SETTLE_CYC-1)) begin
            settle_cnt <= '0;
            state      <= ACCUM;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ACCUM: begin
          if (conv_s) begin
            if (conv_cnt == dwell_q - 1'b1) begin
              res_q     <= '{chan: mux_sel, count: ones_cnt + DWELL_W'(comp_s)};
              res_valid <= 1'b1;
              conv_cnt  <= '0;
              ones_cnt  <= '0;
              state     <= EMIT;
            end else begin
              conv_cnt <= conv_cnt + 1'b1;
              ones_cnt <= ones_cnt + DWELL_W'(comp_s);
            end
          end
        end
        EMIT: begin
          if (conv_s) overrun <= 1'b1;
          if (res_valid && res_ready) begin
            res_valid  <= 1'b0;
            settle_cnt <= '0;
            if (nxt[SEL_W]) begin
              mux_sel <= nxt[SEL_W-1:0];
              state   <= SETTLE;
            end else if (cont_q) begin
              mux_sel <= lowest_bit(mask_q);
              state   <= SETTLE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frida_scan_seq.sv
// Bench for frida_scan_seq (default build, inputs used directly).
// Directed scenarios for reset, the two-channel example, backpressure,
// continuous single-channel looping with stop, and ignored starts; then
// randomized single-pass scans against a per-channel procedural model.
module tb_frida_scan_seq;
  localparam int SETTLE_CYC = 2;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        start = 1'b0, stop = 1'b0, cont = 1'b0;
  logic [15:0] chan_mask = '0;
  logic [7:0]  dwell = '0;
  logic        conv_done = 1'b0, comp_in = 1'b0, res_ready = 1'b0;
  logic [3:0]  mux_sel, res_chan;
  logic [7:0]  res_count;
  logic        busy, res_valid, overrun;

  frida_scan_seq #(.N_ADC(16), .SEL_W(4), .DWELL_W(8), .SETTLE_CYC(SETTLE_CYC)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .stop(stop), .cont(cont),
    .chan_mask(chan_mask), .dwell(dwell), .conv_done(conv_done), .comp_in(comp_in),
    .mux_sel(mux_sel), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_chan(res_chan), .res_count(res_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state for the random scans.
  logic        exp_busy = 1'b0, exp_valid = 1'b0, exp_ovr = 1'b0;
  logic [3:0]  exp_mux = '0;
  logic [11:0] exp_q[$];
  bit          model_done;

  // Channel-by-channel view of one single-pass scan: settle window, then the
  // first d conversions, then wait for the consumer to take the result.
  task automatic model(input logic [15:0] m, input logic [7:0] d);
    int chans[$];
    int ones, conv;
    for (int i = 0; i < 16; i++) if (m[i]) chans.push_back(i);
    @(posedge clk);
    exp_busy = 1'b1;
    exp_ovr  = 1'b0;
    foreach (chans[k]) begin
      exp_mux = 4'(chans[k]);
      repeat (SETTLE_CYC) @(posedge clk);
      conv = 0;
      ones = 0;
      while (conv < int'(d)) begin
        @(posedge clk);
        if (conv_done) begin
          conv++;
          ones += int'(comp_in);
        end
      end
      exp_q.push_back({4'(chans[k]), 8'(ones)});
      exp_valid = 1'b1;
      do begin
        @(posedge clk);
        if (conv_done) exp_ovr = 1'b1;
      end while (!res_ready);
      exp_valid = 1'b0;
    end
    exp_busy   = 1'b0;
    model_done = 1'b1;
  endtask

  // Random stimulus; also scrambles config and fires starts while busy.
  task automatic drive();
    logic [11:0] e;
    while (!model_done) begin
      @(negedge clk);
      start = 1'b0;
      chk("busy", busy, exp_busy);
      chk("mux_sel", mux_sel, exp_mux);
      chk("res_valid", res_valid, exp_valid);
      conv_done = ($urandom_range(0, 2) != 0);
      comp_in   = 1'($urandom_range(0, 1));
      res_ready = ($urandom_range(0, 2) == 0);
      chan_mask = 16'($urandom);
      dwell     = 8'($urandom);
      cont      = 1'($urandom_range(0, 1));
      if (exp_busy && $urandom_range(0, 15) == 0) start = 1'b1;
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) chk("res_extra", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("res_chan", res_chan, e[11:8]);
          chk("res_count", res_count, e[7:0]);
        end
      end
    end
  endtask

  task automatic scan(input logic [15:0] m, input logic [7:0] d);
    @(negedge clk);
    chan_mask = m; dwell = d; cont = 1'b0; start = 1'b1;
    conv_done = 1'b0; res_ready = 1'b0; model_done = 1'b0;
    fork
      model(m, d);
      drive();
    join
    chk("overrun", overrun, exp_ovr);
    chk("leftover", exp_q.size(), 0);
  endtask

  initial begin
    int pat0[4] = '{1, 0, 1, 1};
    int nres, last;
    logic [15:0] m;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);      chk("rst_mux", mux_sel, 0);
    chk("rst_valid", res_valid, 0); chk("rst_chan", res_chan, 0);
    chk("rst_count", res_count, 0); chk("rst_ovr", overrun, 0);
    rst_b = 1'b1;

    // Reset asserted mid-ACCUM
    @(negedge clk); chan_mask = 16'h0004; dwell = 8; cont = 0; start = 1;
    @(negedge clk); start = 0;
    repeat (3) @(negedge clk);
    chk("t1_busy_pre", busy, 1); chk("t1_mux_pre", mux_sel, 2);
    rst_b = 1'b0; #1;
    chk("t1_busy", busy, 0); chk("t1_mux", mux_sel, 0); chk("t1_valid", res_valid, 0);
    chk("t1_chan", res_chan, 0); chk("t1_count", res_count, 0); chk("t1_ovr", overrun, 0);
    @(negedge clk); rst_b = 1'b1;
    @(negedge clk); chk("t1_idle", busy, 0);

    // Two-channel example; conversions during settle must be ignored
    @(negedge clk); chan_mask = 16'h0005; dwell = 4; cont = 0; start = 1; res_ready = 0;
    @(negedge clk); start = 0; conv_done = 1; comp_in = 1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin @(negedge clk); comp_in = 1'(pat0[k]); end
    @(negedge clk); conv_done = 0;
    chk("t2_v0", res_valid, 1); chk("t2_chan0", res_chan, 0); chk("t2_cnt0", res_count, 3);
    res_ready = 1;
    @(negedge clk); res_ready = 0;
    chk("t2_gap_valid", res_valid, 0); chk("t2_mux2", mux_sel, 2); chk("t2_busy", busy, 1);
    conv_done = 1; comp_in = 1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin @(negedge clk); comp_in = 0; end
    @(negedge clk); conv_done = 0;
    chk("t2_v1", res_valid, 1); chk("t2_chan1", res_chan, 2); chk("t2_cnt1", res_count, 0);
    res_ready = 1;
    @(negedge clk); res_ready = 0;
    chk("t2_done_busy", busy, 0); chk("t2_done_mux", mux_sel, 2);
    chk("t2_done_valid", res_valid, 0); chk("t2_done_ovr", overrun, 0);

    // Backpressure with conversions arriving in EMIT
    @(negedge clk); chan_mask = 16'h0002; dwell = 2; cont = 0; start = 1;
    conv_done = 1; comp_in = 1; res_ready = 0;
    @(negedge clk); start = 0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("t3_valid", res_valid, 1); chk("t3_chan", res_chan, 1); chk("t3_cnt", res_count, 2);
      conv_done = 1'(i % 2);
      @(negedge clk);
    end
    chk("t3_ovr", overrun, 1);
    res_ready = 1;
    @(negedge clk); res_ready = 0; conv_done = 0;
    chk("t3_valid_drop", res_valid, 0); chk("t3_busy", busy, 0);
    @(negedge clk); chk("t3_one_only", res_valid, 0);

    // Single channel, continuous: one result every SETTLE_CYC+2 cycles, then stop
    @(negedge clk); chan_mask = 16'h8000; dwell = 1; cont = 1; start = 1;
    conv_done = 1; comp_in = 1; res_ready = 1;
    nres = 0; last = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk); start = 0;
      chk("t4_mux", mux_sel, 15);
      if (res_valid) begin
        nres++;
        chk("t4_chan", res_chan, 15); chk("t4_cnt", res_count, 1);
        if (last > 0) chk("t4_gap", c - last, SETTLE_CYC + 2);
        last = c;
      end
    end
    chk("t4_nres", nres, 3);
    stop = 1;
    @(negedge clk); stop = 0; res_ready = 0; conv_done = 0;
    chk("t4_stop_busy", busy, 0); chk("t4_stop_valid", res_valid, 0); chk("t4_stop_mux", mux_sel, 15);

    // Ignored starts
    @(negedge clk); chan_mask = 16'h0000; dwell = 3; cont = 0; start = 1;
    @(negedge clk); start = 0;
    @(negedge clk); chk("t5_mask0", busy, 0);
    chan_mask = 16'h0001; dwell = 0; start = 1;
    @(negedge clk); start = 0;
    @(negedge clk); chk("t5_dwell0", busy, 0);
    dwell = 3; start = 1; stop = 1;
    @(negedge clk); start = 0; stop = 0;
    chk("t5_startstop", busy, 0);
    @(negedge clk); chk("t5_startstop2", busy, 0);

    // Randomized single-pass scans
    for (int s = 0; s < 24; s++) begin
      case (s % 4)
        0: m = 16'h0001 << $urandom_range(0, 15);
        1: m = (s == 1) ? 16'h8001 : 16'($urandom) | 16'h0001;
        default: m = 16'($urandom);
      endcase
      if (m == 0) m = 16'h0100;
      scan(m, 8'($urandom_range(1, 5)));
    end
    scan(16'h0100, 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
